// File: rtl/accumulator_pkg.sv
// Shared SAP datapath constants: word/half widths and the A register reset value.
package accumulator_pkg;

  localparam int DATA_W = 16;
  localparam int LOW_W  = 8;

  localparam logic [DATA_W-1:0] ACC_RESET_VAL = '0;

endpackage

// File: rtl/accumulator.sv
// A register of the SAP datapath: full-word or low-half capture from the bus, 1-cycle load latency.
// No backpressure: enables are level-sensitive and reload on every edge they are held; async active-low clear.
module accumulator #(
  parameter int DATA_W = accumulator_pkg::DATA_W,
  parameter int LOW_W  = DATA_W / 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_write,
  input  logic              acc_lower_write,
  input  logic [DATA_W-1:0] bus,
  output logic [DATA_W-1:0] aout
);

  import accumulator_pkg::*;

  logic [DATA_W-1:0] acc_q;

  // Full-word load outranks the low-half load; upper half is kept on a partial load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= DATA_W'(ACC_RESET_VAL);
    end else if (acc_write) begin
      acc_q <= bus;
    end else if (acc_lower_write) begin
      acc_q[LOW_W-1:0] <= bus[LOW_W-1:0];
    end
  end

  assign aout = acc_q;

endmodule

// File: tb/tb_accumulator.sv
// Directed plus randomized check of the accumulator against a word-level reference value.
module tb_accumulator;

  logic        clk;
  logic        rst;
  logic        acc_write;
  logic        acc_lower_write;
  logic [15:0] bus;
  logic [15:0] aout;

  int checks = 0;
  int errors = 0;

  // Reference contents of the A register, updated from the behavioural rules only.
  logic [15:0] model;

  accumulator dut (
    .clk             (clk),
    .rst             (rst),
    .acc_write       (acc_write),
    .acc_lower_write (acc_lower_write),
    .bus             (bus),
    .aout            (aout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] exp);
    checks++;
    assert (aout === exp) else begin
      errors++;
      $error("FAIL %s aout=%h expected=%h", tag, aout, exp);
    end
  endtask

  // Apply inputs just after an edge, take the next rising edge, then compare 1 ns later.
  task automatic cycle(input string tag, input logic aw, input logic lw, input logic [15:0] b);
    acc_write       = aw;
    acc_lower_write = lw;
    bus             = b;
    @(posedge clk);
    if (aw)
      model = b;
    else if (lw)
      model = (model & 16'hFF00) | (b & 16'h00FF);
    #1;
    check(tag, model);
  endtask

  // Short reset pulse placed between edges; called right after a cycle's compare point.
  task automatic pulse_reset(input string tag);
    #2 rst = 1'b0;
    model = 16'h0000;
    #1;
    check(tag, 16'h0000);
    #1 rst = 1'b1;
  endtask

  initial begin
    rst             = 1'b1;
    acc_write       = 1'b0;
    acc_lower_write = 1'b0;
    bus             = 16'h0000;
    model           = 16'h0000;

    // Power-up reset, asserted before the first clock edge.
    #3 rst = 1'b0;
    #1;
    check("reset_async", 16'h0000);
    #4 rst = 1'b1;
    cycle("idle_after_reset_0", 1'b0, 1'b0, 16'hBEEF);
    cycle("idle_after_reset_1", 1'b0, 1'b0, 16'h5A5A);

    // Full load, then hold while the bus moves.
    cycle("full_load_012c", 1'b1, 1'b0, 16'd300);
    check("full_load_const", 16'h012C);
    cycle("hold_012c", 1'b0, 1'b0, 16'hFFFF);
    bus = 16'h7777;
    #3;
    check("bus_between_edges", 16'h012C);

    // Low-half load keeps the upper byte.
    cycle("lower_keep_upper", 1'b0, 1'b1, 16'hDEDE);
    check("lower_keep_upper_const", 16'h01DE);

    // Both enables: full load wins.
    cycle("both_enables", 1'b1, 1'b1, 16'hA55A);
    check("both_enables_const", 16'hA55A);

    // Low-half load after a clear, held across two edges.
    pulse_reset("clear_pulse");
    cycle("lower_after_clear_0", 1'b0, 1'b1, 16'hDEDE);
    cycle("lower_after_clear_1", 1'b0, 1'b1, 16'hDEDE);
    check("lower_after_clear_const", 16'h00DE);

    // Reset while acc_write streams 0x1234.
    cycle("stream_1234", 1'b1, 1'b0, 16'h1234);
    #2 rst = 1'b0;
    model = 16'h0000;
    #1;
    check("reset_mid_write", 16'h0000);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("reset_held_edge", 16'h0000);
    end
    #2 rst = 1'b1;
    cycle("resume_after_reset", 1'b1, 1'b0, 16'h1234);
    check("resume_after_reset_const", 16'h1234);

    // Randomized traffic with occasional asynchronous clears.
    for (int i = 0; i < 300; i++) begin
      cycle("random", 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
            16'($urandom));
      if ($urandom_range(0, 19) == 0)
        pulse_reset("random_reset");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d expected_end_before=200000ns", checks);
    $fatal(1, "watchdog");
  end

endmodule
